// File: rtl/upg_pkg.sv
// Shared definitions for the UART program loader.
//   upg_state_e : loader FSM states (S_IDLE..S_WRITE)
//   TGT_*       : segment target / terminator byte codes
//   UPG_IDX_W   : default word-index width; MAX_WORDS = 1 << UPG_IDX_W
//   baud_div    : clocks per UART bit, shared by receiver and echo transmitter
package upg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TGT   = 3'd1,
    S_CNT_L = 3'd2,
    S_CNT_H = 3'd3,
    S_DATA  = 3'd4,
    S_WRITE = 3'd5
  } upg_state_e;

  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;
  localparam logic [7:0] TGT_END  = 8'hFF;

  localparam int UPG_IDX_W = 14;

  function automatic int max_words(input int idx_w);
    return 1 << idx_w;
  endfunction

  localparam int MAX_WORDS = max_words(UPG_IDX_W);

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   rx_sync    : receive line, already synchronized to clk (idle high)
//   byte_o     : received byte, valid while byte_valid=1
//   byte_valid : one-cycle strobe, frame ended with a good stop bit
//   frame_err  : one-cycle strobe, stop bit sampled low
module uart_rx_byte
  import upg_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 128_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic [7:0] byte_o,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e     st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      prev_q     <= 1'b1;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      prev_q     <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st_q)
        R_IDLE: begin
          if (prev_q && !rx_sync) begin
            st_q  <= R_START;
            cnt_q <= '0;
          end
        end
        R_START: begin
          // Mid-start-bit check: a line already back high was only a glitch.
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
            sh_q  <= {rx_sync, sh_q[7:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) st_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
            st_q  <= R_IDLE;
            if (rx_sync) begin
              byte_o     <= sh_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses [TGT][CNT_L][CNT_H][N x 4 bytes] segments from
// the rx stream and writes little-endian 32-bit words to imem/dmem.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   start_pg   : program-mode request level; acts on its rising edge
//   rx         : UART receive line, asynchronous to clk
//   tx         : echo of received bytes when UPG_ECHO_EN is defined, else 1
//   upg_wen_o  : one-cycle write strobe
//   upg_adr_o  : {target (0=imem, 1=dmem), word index}
//   upg_dat_o  : write data, held after each write
//   upg_done_o : 1 when not programming
//   upg_err_o  : sticky protocol/framing error, cleared by start_pg edge
// Build option: define UPG_ECHO_EN to build the 8N1 echo transmitter.
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 128_000,
  parameter int IDX_W    = UPG_IDX_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_pg,
  input  logic           rx,
  output logic           tx,
  output logic           upg_wen_o,
  output logic [IDX_W:0] upg_adr_o,
  output logic [31:0]    upg_dat_o,
  output logic           upg_done_o,
  output logic           upg_err_o
);

  localparam int MAXW = max_words(IDX_W);

  logic       rx_s1_q, rx_s2_q;
  logic       sp_s1_q, sp_s2_q, sp_prev_q;
  logic       start_edge;
  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      sp_s1_q   <= 1'b0;
      sp_s2_q   <= 1'b0;
      sp_prev_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      sp_s1_q   <= start_pg;
      sp_s2_q   <= sp_s1_q;
      sp_prev_q <= sp_s2_q;
    end
  end

  assign start_edge = sp_s2_q & ~sp_prev_q;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_sync    (rx_s2_q),
    .byte_o     (rx_byte),
    .byte_valid (rx_vld),
    .frame_err  (rx_ferr)
  );

  upg_state_e       state_q;
  logic             tgt_q;
  logic [7:0]       cnt_l_q;
  logic [IDX_W:0]   n_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       k_q;
  logic [23:0]      word_q;
  logic [15:0]      n_in;
  logic [IDX_W:0]   idx_inc;

  assign n_in    = {rx_byte, cnt_l_q};
  assign idx_inc = {1'b0, idx_q} + {{IDX_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tgt_q      <= 1'b0;
      cnt_l_q    <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      k_q        <= '0;
      word_q     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b1;
      upg_err_o  <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      if (start_edge) begin
        // Restart from any state; a partial word is dropped via k_q.
        state_q    <= S_TGT;
        upg_done_o <= 1'b0;
        upg_err_o  <= 1'b0;
        idx_q      <= '0;
        k_q        <= '0;
      end else if (rx_ferr && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        upg_err_o  <= 1'b1;
        upg_done_o <= 1'b1;
      end else begin
        case (state_q)
          S_TGT: if (rx_vld) begin
            case (rx_byte)
              TGT_IMEM, TGT_DMEM: begin
                tgt_q   <= rx_byte[0];
                state_q <= S_CNT_L;
              end
              TGT_END: begin
                state_q    <= S_IDLE;
                upg_done_o <= 1'b1;
              end
              default: begin
                state_q    <= S_IDLE;
                upg_err_o  <= 1'b1;
                upg_done_o <= 1'b1;
              end
            endcase
          end
          S_CNT_L: if (rx_vld) begin
            cnt_l_q <= rx_byte;
            state_q <= S_CNT_H;
          end
          S_CNT_H: if (rx_vld) begin
            if (n_in == 16'd0) begin
              state_q <= S_TGT;
            end else if (32'(n_in) > 32'(MAXW)) begin
              state_q    <= S_IDLE;
              upg_err_o  <= 1'b1;
              upg_done_o <= 1'b1;
            end else begin
              n_q     <= n_in[IDX_W:0];
              k_q     <= '0;
              state_q <= S_DATA;
            end
          end
          S_DATA: if (rx_vld) begin
            // Bytes shift in from the top so the 4th byte lands in [31:24].
            if (k_q == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= {tgt_q, idx_q};
              upg_dat_o <= {rx_byte, word_q};
              state_q   <= S_WRITE;
            end else begin
              word_q <= {rx_byte, word_q[23:8]};
              k_q    <= k_q + 1'b1;
            end
          end
          S_WRITE: begin
            k_q <= '0;
            if (idx_inc == n_q) begin
              idx_q   <= '0;
              state_q <= S_TGT;
            end else begin
              idx_q   <= idx_inc[IDX_W-1:0];
              state_q <= S_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UPG_ECHO_EN
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);

  logic          tx_q, busy_q;
  logic [9:0]    frame_q;
  logic [3:0]    tbit_q;
  logic [CW-1:0] tcnt_q;

  // Bytes arriving while a previous echo is still shifting out are skipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      frame_q <= '1;
      tbit_q  <= '0;
      tcnt_q  <= '0;
    end else if (!busy_q) begin
      if (rx_vld) begin
        frame_q <= {1'b1, rx_byte, 1'b0};
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        tbit_q  <= '0;
        tcnt_q  <= '0;
      end
    end else if (tcnt_q == CW'(DIV - 1)) begin
      tcnt_q <= '0;
      if (tbit_q == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        tbit_q <= tbit_q + 1'b1;
        tx_q   <= frame_q[tbit_q + 4'd1];
      end
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int DIV = 10;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_pg = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  int checks = 0;
  int errors = 0;

  logic [46:0] got_q[$];
  logic [46:0] exp_q[$];
  logic [7:0]  rs[$];

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .IDX_W    (14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_pg   (start_pg),
    .rx         (rx),
    .tx         (tx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .upg_err_o  (upg_err_o)
  );

  always @(negedge clk) begin
    if (upg_wen_o === 1'b1) got_q.push_back({upg_adr_o, upg_dat_o});
  end

`ifdef UPG_ECHO_EN
  logic [8:0] echo_q[$];
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        eb[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      echo_q.push_back({tx, eb});
    end
  end
`endif

  typedef struct packed {
    logic            start;
    logic [5:0]      n;
    logic [255:0]    b;
    logic            bad;
    logic [1:0]      nw;
    logic [2:0][46:0] w;
    logic            err;
    logic            done;
  } vec_t;

  vec_t vt [0:7];

  function automatic logic [46:0] W(input logic [14:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  function automatic vec_t mkv(input logic st, input int n, input logic [255:0] raw,
                               input logic bad, input int nw, input logic [46:0] w0,
                               input logic [46:0] w1, input logic [46:0] w2,
                               input logic err, input logic done);
    vec_t r;
    r.start = st;
    r.n     = 6'(n);
    r.b     = raw << (256 - 8 * n);
    r.bad   = bad;
    r.nw    = 2'(nw);
    r.w[0]  = w0;
    r.w[1]  = w1;
    r.w[2]  = w2;
    r.err   = err;
    r.done  = done;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_raw(input logic [255:0] raw, input int n);
    logic [255:0] b;
    b = raw << (256 - 8 * n);
    for (int i = 0; i < n; i++) send_byte(b[255 - 8 * i -: 8], 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_pg = 1'b1;
    repeat (4) @(negedge clk);
    start_pg = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_writes(input string name);
    chk($sformatf("%s_nwrites", name), 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s_write%0d", name, k), 64'(got_q[k]), 64'(exp_q[k]));
  endtask

  // Reference: parse the byte stream segment by segment.
  task automatic model(input logic [7:0] s[$], input bit bad,
                       output logic e_err, output logic e_done);
    int pos, lim, n;
    logic [7:0] t;
    bit ended;
    pos = 0;
    lim = bad ? s.size() - 1 : s.size();
    ended = 0;
    e_err = 0;
    exp_q.delete();
    while (!ended && pos < lim) begin
      t = s[pos];
      pos++;
      if (t == 8'hFF) begin
        ended = 1;
      end else if (t > 8'h01) begin
        ended = 1;
        e_err = 1;
      end else if (pos + 2 <= lim) begin
        n = int'({s[pos + 1], s[pos]});
        pos += 2;
        if (n > 16384) begin
          ended = 1;
          e_err = 1;
        end else begin
          for (int w = 0; w < n; w++) begin
            if (pos + 4 > lim) begin
              pos = lim;
              break;
            end
            exp_q.push_back({t[0], w[13:0], s[pos + 3], s[pos + 2], s[pos + 1], s[pos]});
            pos += 4;
          end
        end
      end else begin
        pos = lim;
      end
    end
    if (bad && !ended) begin
      ended = 1;
      e_err = 1;
    end
    e_done = ended;
  endtask

  initial begin
    logic [7:0] bb;
    logic m_err, m_done;
    bit bad;
    int nseg, nw, term;

    vt[0] = mkv(0, 8,  64'h00010011223344FF, 0, 0, '0, '0, '0, 0, 1);
    vt[1] = mkv(1, 12, 96'h000200_78563412_EFBEADDE_FF, 0, 2,
                W(15'h0000, 32'h12345678), W(15'h0001, 32'hDEADBEEF), '0, 0, 1);
    vt[2] = mkv(1, 11, 88'h010100_04030201_000000_FF, 0, 1,
                W(15'h4000, 32'h01020304), '0, '0, 0, 1);
    vt[3] = mkv(1, 6,  48'h010100_AABB_55, 1, 0, '0, '0, '0, 1, 1);
    vt[4] = mkv(1, 1,  8'h07, 0, 0, '0, '0, '0, 1, 1);
    vt[5] = mkv(1, 3,  24'h000140, 0, 0, '0, '0, '0, 1, 1);
    vt[6] = mkv(1, 7,  56'h000040_A1A2A3A4, 0, 1, W(15'h0000, 32'hA4A3A2A1), '0, '0, 0, 0);
    vt[7] = mkv(1, 19, 152'h010200_10203040_50607080_000100_C1C2C3C4_FF, 0, 3,
                W(15'h4000, 32'h40302010), W(15'h4001, 32'h80706050),
                W(15'h0000, 32'hC4C3C2C1), 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(upg_done_o), 64'd1);
    chk("rst_wen",  64'(upg_wen_o),  64'd0);
    chk("rst_adr",  64'(upg_adr_o),  64'd0);
    chk("rst_dat",  64'(upg_dat_o),  64'd0);
    chk("rst_err",  64'(upg_err_o),  64'd0);
    chk("rst_tx",   64'(tx),         64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < int'(vt[v].nw); k++) exp_q.push_back(vt[v].w[k]);
      if (vt[v].start) begin
        pulse_start();
        chk($sformatf("vec%0d_start_done", v), 64'(upg_done_o), 64'd0);
        chk($sformatf("vec%0d_start_err", v),  64'(upg_err_o),  64'd0);
      end
      for (int i = 0; i < int'(vt[v].n); i++) begin
        bb = vt[v].b[255 - 8 * i -: 8];
        send_byte(bb, !(vt[v].bad && i == int'(vt[v].n) - 1));
      end
      repeat (5) @(negedge clk);
      cmp_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_err", v),  64'(upg_err_o),  64'(vt[v].err));
      chk($sformatf("vec%0d_done", v), 64'(upg_done_o), 64'(vt[v].done));
      if (vt[v].nw != 0) begin
        chk($sformatf("vec%0d_adr_hold", v), 64'(upg_adr_o), 64'(vt[v].w[vt[v].nw - 1][46:32]));
        chk($sformatf("vec%0d_dat_hold", v), 64'(upg_dat_o), 64'(vt[v].w[vt[v].nw - 1][31:0]));
      end
    end

    // Restart mid-word; start_pg stays high through the new stream
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(W(15'h0000, 32'h44332211));
    pulse_start();
    send_raw(40'h0001001122, 5);
    @(negedge clk);
    start_pg = 1'b1;
    repeat (4) @(negedge clk);
    chk("restart_done", 64'(upg_done_o), 64'd0);
    send_raw(64'h00010011223344FF, 8);
    start_pg = 1'b0;
    cmp_writes("restart");
    chk("restart_err_end",  64'(upg_err_o),  64'd0);
    chk("restart_done_end", 64'(upg_done_o), 64'd1);

    // Asynchronous reset mid-stream
    pulse_start();
    send_raw(40'h0002001122, 5);
    #3 rst = 1'b0;
    #1;
    chk("arst_done", 64'(upg_done_o), 64'd1);
    chk("arst_wen",  64'(upg_wen_o),  64'd0);
    chk("arst_adr",  64'(upg_adr_o),  64'd0);
    chk("arst_dat",  64'(upg_dat_o),  64'd0);
    chk("arst_err",  64'(upg_err_o),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    send_raw(64'h00010011223344FF, 8);
    cmp_writes("arst_idle");
    chk("arst_idle_done", 64'(upg_done_o), 64'd1);

    // Short low glitch on rx must not become a byte
    repeat (120) @(negedge clk);
`ifdef UPG_ECHO_EN
    echo_q.delete();
`endif
    pulse_start();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
`ifdef UPG_ECHO_EN
    chk("glitch_echo_cnt", 64'(echo_q.size()), 64'd0);
`endif
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(W(15'h0000, 32'h44332211));
    send_raw(64'h00010011223344FF, 8);
    cmp_writes("glitch");
    chk("glitch_err",  64'(upg_err_o),  64'd0);
    chk("glitch_done", 64'(upg_done_o), 64'd1);

    // Echo of a single byte
    repeat (120) @(negedge clk);
`ifdef UPG_ECHO_EN
    echo_q.delete();
    send_byte(8'hA5, 1'b1);
    repeat (120) @(negedge clk);
    chk("echo_cnt", 64'(echo_q.size()), 64'd1);
    if (echo_q.size() > 0) chk("echo_frame", 64'(echo_q[0]), 64'h1A5);
`else
    send_byte(8'hA5, 1'b1);
    chk("tx_idle", 64'(tx), 64'd1);
    repeat (20) @(negedge clk);
    chk("tx_idle_after", 64'(tx), 64'd1);
`endif

    // Randomized streams against the reference parser
    for (int it = 0; it < 5; it++) begin
      rs.delete();
      bad = 0;
      nseg = $urandom_range(1, 3);
      for (int g = 0; g < nseg; g++) begin
        rs.push_back(8'($urandom_range(0, 1)));
        nw = $urandom_range(0, 3);
        rs.push_back(8'(nw));
        rs.push_back(8'h00);
        for (int j = 0; j < 4 * nw; j++) rs.push_back(8'($urandom));
      end
      term = $urandom_range(0, 3);
      case (term)
        0, 1:    rs.push_back(8'hFF);
        2:       rs.push_back(8'($urandom_range(2, 254)));
        default: begin
          rs.push_back(8'($urandom));
          bad = 1;
        end
      endcase
      model(rs, bad, m_err, m_done);
      got_q.delete();
      pulse_start();
      for (int i = 0; i < rs.size(); i++) send_byte(rs[i], !(bad && i == rs.size() - 1));
      repeat (5) @(negedge clk);
      cmp_writes($sformatf("rand%0d", it));
      chk($sformatf("rand%0d_err", it),  64'(upg_err_o),  64'(m_err));
      chk($sformatf("rand%0d_done", it), 64'(upg_done_o), 64'(m_done));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
